pdp8_pin_serdes: RTL and testbench

Parametrised, full-duplex word serialiser/deserialiser that carries PDP-8 register-width words (AC, PC, MB, switch register, …) across the 8-bit Tiny Tapeout pin lanes of `tt_um_markgarnold_pdp8`. It generalises the fixed byte-wide pin mapping to any word width, beat width, channel count and output pacing. Each frame is a channel-tagged header beat followed by little-endian data beats. It sits between the PDP-8 core (valid/ready word side) and the `uo_out` / `uio_*` pin lanes (strobe side).

---
 rtl/pdp8_serdes_pkg.sv | 21 ++
 rtl/pdp8_pin_serdes_if.sv | 33 +++
 rtl/pdp8_serdes_rx.sv | 99 +++++++++
 rtl/pdp8_pin_serdes.sv | 124 ++++++++++++
 tb/tb_pdp8_pin_serdes.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/pdp8_serdes_pkg.sv
// Shared types and sizing helpers for the PDP-8 pin-lane word serdes.
// Beat geometry is derived here so the TX and RX sides agree on it.
package pdp8_serdes_pkg;

  typedef enum logic [1:0] {TX_IDLE, TX_HDR, TX_DATA} tx_state_e;
  typedef enum logic       {RX_IDLE, RX_DATA}          rx_state_e;

  function automatic int nbeats(input int word_w, input int beat_w);
    return (word_w + beat_w - 1) / beat_w;
  endfunction

  function automatic int ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // The start marker is always the top bit of a beat.
  function automatic int mark_bit(input int beat_w);
    return beat_w - 1;
  endfunction

endpackage

// File: rtl/pdp8_pin_serdes_if.sv
// Word-side handshake plus pin-lane beats for the pdp8 serdes.
// The slave modport is the serdes view; master is the core/pin side.
interface pdp8_pin_serdes_if #(
    parameter int WORD_W = 12,
    parameter int BEAT_W = 8,
    parameter int CH_W   = 2
);
    logic              tx_valid;
    logic              tx_ready;
    logic [CH_W-1:0]   tx_ch;
    logic [WORD_W-1:0] tx_word;
    logic [BEAT_W-1:0] out_data;
    logic              out_strobe;
    logic              out_last;
    logic [BEAT_W-1:0] in_data;
    logic              in_strobe;
    logic              rx_valid;
    logic [CH_W-1:0]   rx_ch;
    logic [WORD_W-1:0] rx_word;
    logic              rx_err;

    modport slave (
        input  tx_valid, tx_ch, tx_word, in_data, in_strobe,
        output tx_ready, out_data, out_strobe, out_last,
        output rx_valid, rx_ch, rx_word, rx_err
    );

    modport master (
        output tx_valid, tx_ch, tx_word, in_data, in_strobe,
        input  tx_ready, out_data, out_strobe, out_last,
        input  rx_valid, rx_ch, rx_word, rx_err
    );
endinterface

// File: rtl/pdp8_serdes_rx.sv
// Receive side: header decode, little-endian beat assembly, gap timeout.
// Frames with an out-of-range channel are consumed but never delivered.
module pdp8_serdes_rx
    import pdp8_serdes_pkg::*;
#(
    parameter int WORD_W     = 12,
    parameter int BEAT_W     = 8,
    parameter int NCH        = 4,
    parameter int RX_TIMEOUT = 255,
    localparam int CH_W      = ch_w(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BEAT_W-1:0] in_data_i,
    input  logic              in_strobe_i,
    output logic              rx_valid_o,
    output logic [CH_W-1:0]   rx_ch_o,
    output logic [WORD_W-1:0] rx_word_o,
    output logic              rx_err_o
);
    localparam int NB   = nbeats(WORD_W, BEAT_W);
    localparam int AW   = NB * BEAT_W;
    localparam int MARK = mark_bit(BEAT_W);
    localparam int BC_W = $clog2(NB + 1);
    localparam int TO_W = $clog2(RX_TIMEOUT + 1);

    rx_state_e         state_q;
    logic              drop_q;
    logic [BC_W-1:0]   cnt_q;
    logic [TO_W-1:0]   to_q;
    logic [AW-1:0]     asm_q, asm_d;
    logic [CH_W-1:0]   ch_q;
    logic              rx_valid_q, rx_err_q;
    logic [CH_W-1:0]   rx_ch_q;
    logic [WORD_W-1:0] rx_word_q;
    logic              is_hdr, ch_ok;

    assign is_hdr = in_data_i[MARK];
    // Range check uses every non-marker bit, so stray high bits count as a bad channel.
    assign ch_ok  = 32'(in_data_i[MARK-1:0]) < NCH;
    assign asm_d  = (asm_q >> BEAT_W) | (AW'(in_data_i) << (AW - BEAT_W));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RX_IDLE;
            drop_q     <= 1'b0;
            cnt_q      <= '0;
            to_q       <= '0;
            asm_q      <= '0;
            ch_q       <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            rx_ch_q    <= '0;
            rx_word_q  <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (in_strobe_i && is_hdr) begin
                        state_q  <= RX_DATA;
                        drop_q   <= !ch_ok;
                        rx_err_q <= !ch_ok;
                        ch_q     <= in_data_i[CH_W-1:0];
                        cnt_q    <= '0;
                        to_q     <= '0;
                    end
                end
                RX_DATA: begin
                    if (in_strobe_i) begin
                        to_q  <= '0;
                        asm_q <= asm_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == BC_W'(NB - 1)) begin
                            state_q <= RX_IDLE;
                            if (!drop_q) begin
                                rx_valid_q <= 1'b1;
                                rx_word_q  <= asm_d[WORD_W-1:0];
                                rx_ch_q    <= ch_q;
                            end
                        end
                    end else if (to_q == TO_W'(RX_TIMEOUT - 1)) begin
                        // A dropped frame was already reported at its header.
                        state_q  <= RX_IDLE;
                        rx_err_q <= !drop_q;
                    end else begin
                        to_q <= to_q + 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign rx_valid_o = rx_valid_q;
    assign rx_err_o   = rx_err_q;
    assign rx_ch_o    = rx_ch_q;
    assign rx_word_o  = rx_word_q;
endmodule

// File: rtl/pdp8_pin_serdes.sv
// Full-duplex word serdes between the PDP-8 core and 8-bit pin lanes.
// TX frames a word as header + LSB-first data beats; RX lives in a sub-module.
module pdp8_pin_serdes
    import pdp8_serdes_pkg::*;
#(
    parameter int WORD_W     = 12,
    parameter int BEAT_W     = 8,
    parameter int NCH        = 4,
    parameter int PACE       = 1,
    parameter int RX_TIMEOUT = 255
) (
    input logic                clk,
    input logic                rst,
    pdp8_pin_serdes_if.slave   bus
);
    localparam int NB   = nbeats(WORD_W, BEAT_W);
    localparam int CH_W = ch_w(NCH);
    localparam int SH_W = NB * BEAT_W;
    localparam int MARK = mark_bit(BEAT_W);
    localparam int PC_W = (PACE > 1) ? $clog2(PACE) : 1;
    localparam int BC_W = $clog2(NB + 1);

    tx_state_e         state_q;
    logic              tx_ready_q;
    logic [BEAT_W-1:0] out_data_q;
    logic              out_strobe_q, out_last_q;
    logic [PC_W-1:0]   pace_q;
    logic [BC_W-1:0]   beat_q;
    logic [SH_W-1:0]   sh_q;
    logic [BEAT_W-1:0] hdr_d;
    logic              pace_done;

    always_comb begin
        hdr_d             = '0;
        hdr_d[MARK]       = 1'b1;
        hdr_d[CH_W-1:0]   = bus.tx_ch;
    end

    assign pace_done = (pace_q == PC_W'(PACE - 1));

    // beat_q counts data beats already put on the pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= TX_IDLE;
            tx_ready_q   <= 1'b0;
            out_data_q   <= '0;
            out_strobe_q <= 1'b0;
            out_last_q   <= 1'b0;
            pace_q       <= '0;
            beat_q       <= '0;
            sh_q         <= '0;
        end else begin
            out_strobe_q <= 1'b0;
            out_last_q   <= 1'b0;
            case (state_q)
                TX_IDLE: begin
                    out_data_q <= '0;
                    tx_ready_q <= 1'b1;
                    if (bus.tx_valid && tx_ready_q) begin
                        state_q      <= TX_HDR;
                        tx_ready_q   <= 1'b0;
                        out_data_q   <= hdr_d;
                        out_strobe_q <= 1'b1;
                        pace_q       <= '0;
                        beat_q       <= '0;
                        sh_q         <= SH_W'(bus.tx_word);
                    end
                end
                TX_HDR: begin
                    if (!pace_done) begin
                        pace_q <= pace_q + 1'b1;
                    end else begin
                        state_q      <= TX_DATA;
                        pace_q       <= '0;
                        out_data_q   <= sh_q[BEAT_W-1:0];
                        sh_q         <= sh_q >> BEAT_W;
                        out_strobe_q <= 1'b1;
                        out_last_q   <= (NB == 1);
                        beat_q       <= BC_W'(1);
                    end
                end
                TX_DATA: begin
                    if (!pace_done) begin
                        pace_q <= pace_q + 1'b1;
                    end else if (beat_q == BC_W'(NB)) begin
                        state_q    <= TX_IDLE;
                        pace_q     <= '0;
                        out_data_q <= '0;
                        tx_ready_q <= 1'b1;
                    end else begin
                        pace_q       <= '0;
                        out_data_q   <= sh_q[BEAT_W-1:0];
                        sh_q         <= sh_q >> BEAT_W;
                        out_strobe_q <= 1'b1;
                        out_last_q   <= (beat_q == BC_W'(NB - 1));
                        beat_q       <= beat_q + 1'b1;
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

    assign bus.tx_ready   = tx_ready_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_strobe = out_strobe_q;
    assign bus.out_last   = out_last_q;

    pdp8_serdes_rx #(
        .WORD_W     (WORD_W),
        .BEAT_W     (BEAT_W),
        .NCH        (NCH),
        .RX_TIMEOUT (RX_TIMEOUT)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .in_data_i   (bus.in_data),
        .in_strobe_i (bus.in_strobe),
        .rx_valid_o  (bus.rx_valid),
        .rx_ch_o     (bus.rx_ch),
        .rx_word_o   (bus.rx_word),
        .rx_err_o    (bus.rx_err)
    );
endmodule

// File: tb/tb_pdp8_pin_serdes.sv
// Directed bench: default TX/RX framing, slow pacing, error paths, reset, 16/4 loopback.
module tb_pdp8_pin_serdes;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pdp8_pin_serdes_if #(.WORD_W(12), .BEAT_W(8), .CH_W(2)) i1 ();
    pdp8_pin_serdes_if #(.WORD_W(12), .BEAT_W(8), .CH_W(2)) i2 ();
    pdp8_pin_serdes_if #(.WORD_W(16), .BEAT_W(4), .CH_W(3)) i3 ();

    pdp8_pin_serdes u1 (.clk(clk), .rst(rst), .bus(i1));
    pdp8_pin_serdes #(.PACE(3)) u2 (.clk(clk), .rst(rst), .bus(i2));
    pdp8_pin_serdes #(.WORD_W(16), .BEAT_W(4), .NCH(8)) u3 (.clk(clk), .rst(rst), .bus(i3));

    assign i3.in_data   = i3.out_data;
    assign i3.in_strobe = i3.out_strobe;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++; if (i1.tx_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b expected 0", i1.tx_ready); end
        checks++; if ({i1.out_data, i1.out_strobe, i1.out_last} !== 10'h0) begin errors++; $display("FAIL reset_out: got %h expected 0", {i1.out_data, i1.out_strobe, i1.out_last}); end
        checks++; if ({i1.rx_valid, i1.rx_err, i1.rx_ch, i1.rx_word} !== 16'h0) begin errors++; $display("FAIL reset_rx: got %h expected 0", {i1.rx_valid, i1.rx_err, i1.rx_ch, i1.rx_word}); end
        rst = 1'b0;
        tick();
        checks++; if (i1.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b expected 1", i1.tx_ready); end
    endtask

    task automatic test_tx_basic();
        logic [7:0] exp_b [3];
        exp_b = '{8'h82, 8'h5C, 8'h0A};
        i1.tx_valid = 1'b1; i1.tx_ch = 2'd2; i1.tx_word = 12'hA5C;
        for (int k = 0; k < 3; k++) begin
            logic el;
            tick();
            i1.tx_valid = 1'b0; i1.tx_word = 12'h000;
            el = (k == 2);
            checks++; if (i1.out_data !== exp_b[k]) begin errors++; $display("FAIL tx_beat%0d: got %h expected %h", k, i1.out_data, exp_b[k]); end
            checks++; if ({i1.out_strobe, i1.out_last, i1.tx_ready} !== {1'b1, el, 1'b0}) begin errors++; $display("FAIL tx_ctl%0d: got %b expected %b", k, {i1.out_strobe, i1.out_last, i1.tx_ready}, {1'b1, el, 1'b0}); end
        end
        tick();
        checks++; if ({i1.tx_ready, i1.out_strobe, i1.out_data} !== {2'b10, 8'h00}) begin errors++; $display("FAIL tx_done: got %h expected %h", {i1.tx_ready, i1.out_strobe, i1.out_data}, {2'b10, 8'h00}); end
    endtask

    task automatic test_tx_pace();
        logic [7:0] exp_b [3];
        int bad;
        exp_b = '{8'h82, 8'h5C, 8'h0A};
        bad = 0;
        i2.tx_valid = 1'b1; i2.tx_ch = 2'd2; i2.tx_word = 12'hA5C;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                logic es, el;
                tick();
                i2.tx_valid = 1'b0;
                es = (j == 0);
                el = (j == 0) && (k == 2);
                checks++;
                if ({i2.out_data, i2.out_strobe, i2.out_last, i2.tx_ready} !== {exp_b[k], es, el, 1'b0}) begin
                    errors++;
                    $display("FAIL pace_b%0d_c%0d: got %h expected %h", k, j, {i2.out_data, i2.out_strobe, i2.out_last, i2.tx_ready}, {exp_b[k], es, el, 1'b0});
                end
            end
        end
        tick();
        checks++; if ({i2.tx_ready, i2.out_data} !== 9'h100) begin errors++; $display("FAIL pace_done: got %h expected 100", {i2.tx_ready, i2.out_data}); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got_s, got_l;
        i1.tx_valid = 1'b1; i1.tx_ch = 2'd1; i1.tx_word = 12'h123;
        for (int n = 0; n < 8; n++) begin
            tick();
            got_s[n] = i1.out_strobe;
            got_l[n] = i1.out_last;
            if (n == 6) i1.tx_valid = 1'b0;
        end
        checks++; if (got_s !== 8'b0111_0111) begin errors++; $display("FAIL b2b_strobes: got %b expected 01110111", got_s); end
        checks++; if (got_l !== 8'b0100_0100) begin errors++; $display("FAIL b2b_last: got %b expected 01000100", got_l); end
    endtask

    task automatic test_rx_basic();
        i1.in_strobe = 1'b1; i1.in_data = 8'h33;
        tick();
        checks++; if ({i1.rx_err, i1.rx_valid} !== 2'b00) begin errors++; $display("FAIL rx_stray: got %b expected 00", {i1.rx_err, i1.rx_valid}); end
        i1.in_data = 8'h81; tick();
        i1.in_data = 8'hFF; tick();
        checks++; if (i1.rx_valid !== 1'b0) begin errors++; $display("FAIL rx_early: got %b expected 0", i1.rx_valid); end
        i1.in_data = 8'h07; tick();
        i1.in_strobe = 1'b0;
        checks++; if ({i1.rx_valid, i1.rx_err, i1.rx_ch, i1.rx_word} !== {2'b10, 2'd1, 12'h7FF}) begin errors++; $display("FAIL rx_word: got %h expected %h", {i1.rx_valid, i1.rx_err, i1.rx_ch, i1.rx_word}, {2'b10, 2'd1, 12'h7FF}); end
        tick();
        checks++; if (i1.rx_valid !== 1'b0) begin errors++; $display("FAIL rx_pulse: got %b expected 0", i1.rx_valid); end
    endtask

    task automatic test_rx_bad_ch();
        i1.in_strobe = 1'b1; i1.in_data = 8'h86; tick();
        checks++; if (i1.rx_err !== 1'b1) begin errors++; $display("FAIL badch_err: got %b expected 1", i1.rx_err); end
        i1.in_data = 8'h11; tick();
        i1.in_data = 8'h22; tick();
        i1.in_strobe = 1'b0;
        checks++; if ({i1.rx_valid, i1.rx_err} !== 2'b00) begin errors++; $display("FAIL badch_drop: got %b expected 00", {i1.rx_valid, i1.rx_err}); end
        checks++; if ({i1.rx_ch, i1.rx_word} !== {2'd1, 12'h7FF}) begin errors++; $display("FAIL rx_hold: got %h expected %h", {i1.rx_ch, i1.rx_word}, {2'd1, 12'h7FF}); end
        tick();
        i1.in_strobe = 1'b1; i1.in_data = 8'h82; tick();
        i1.in_data = 8'h34; tick();
        i1.in_data = 8'h01; tick();
        i1.in_strobe = 1'b0;
        checks++; if ({i1.rx_valid, i1.rx_err, i1.rx_ch, i1.rx_word} !== {2'b10, 2'd2, 12'h134}) begin errors++; $display("FAIL badch_next: got %h expected %h", {i1.rx_valid, i1.rx_err, i1.rx_ch, i1.rx_word}, {2'b10, 2'd2, 12'h134}); end
    endtask

    task automatic test_rx_timeout();
        i1.in_strobe = 1'b1; i1.in_data = 8'h80; tick();
        i1.in_data = 8'h12; tick();
        i1.in_strobe = 1'b0;
        repeat (254) tick();
        checks++; if (i1.rx_err !== 1'b0) begin errors++; $display("FAIL to_early: got %b expected 0", i1.rx_err); end
        tick();
        checks++; if ({i1.rx_err, i1.rx_valid} !== 2'b10) begin errors++; $display("FAIL to_err: got %b expected 10", {i1.rx_err, i1.rx_valid}); end
        tick();
        checks++; if ({i1.rx_err, i1.rx_word} !== {1'b0, 12'h134}) begin errors++; $display("FAIL to_after: got %h expected %h", {i1.rx_err, i1.rx_word}, {1'b0, 12'h134}); end
    endtask

    task automatic test_reset_mid();
        i1.tx_valid = 1'b1; i1.tx_ch = 2'd3; i1.tx_word = 12'hFFF;
        tick();
        i1.tx_valid = 1'b0;
        i1.in_strobe = 1'b1; i1.in_data = 8'h81;
        tick();
        i1.in_data = 8'hFF;
        rst = 1'b1;
        tick();
        i1.in_strobe = 1'b0;
        checks++; if ({i1.out_data, i1.out_strobe, i1.out_last, i1.tx_ready, i1.rx_valid} !== 12'h0) begin errors++; $display("FAIL rstmid_out: got %h expected 0", {i1.out_data, i1.out_strobe, i1.out_last, i1.tx_ready, i1.rx_valid}); end
        rst = 1'b0;
        i1.in_strobe = 1'b1; i1.in_data = 8'h07;
        tick();
        i1.in_strobe = 1'b0;
        checks++; if ({i1.tx_ready, i1.out_last, i1.out_strobe} !== 3'b100) begin errors++; $display("FAIL rstmid_ready: got %b expected 100", {i1.tx_ready, i1.out_last, i1.out_strobe}); end
        tick();
        checks++; if (i1.rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rx: got %b expected 0", i1.rx_valid); end
    endtask

    task automatic test_loopback();
        logic [15:0] exp_w [100];
        logic [2:0]  exp_c [100];
        int got;
        got = 0;
        fork
            begin
                for (int n = 0; n < 100; n++) begin
                    int t;
                    t = 0;
                    while (!i3.tx_ready && t < 20) begin tick(); t++; end
                    if (t >= 20) begin
                        checks++; errors++;
                        $display("FAIL lb_ready_timeout: got 0 expected 1 at word %0d", n);
                    end
                    exp_w[n] = 16'($urandom);
                    exp_c[n] = 3'($urandom_range(0, 7));
                    i3.tx_valid = 1'b1; i3.tx_word = exp_w[n]; i3.tx_ch = exp_c[n];
                    tick();
                    i3.tx_valid = 1'b0;
                end
            end
            begin
                int cyc;
                cyc = 0;
                while (got < 100 && cyc < 3000) begin
                    tick();
                    cyc++;
                    if (i3.rx_valid) begin
                        checks++;
                        if ({i3.rx_ch, i3.rx_word} !== {exp_c[got], exp_w[got]}) begin
                            errors++;
                            $display("FAIL lb_word%0d: got %h expected %h", got, {i3.rx_ch, i3.rx_word}, {exp_c[got], exp_w[got]});
                        end
                        got++;
                    end
                end
            end
        join
        checks++; if (got !== 100) begin errors++; $display("FAIL lb_count: got %0d expected 100", got); end
    endtask

    initial begin
        i1.tx_valid = 1'b0; i1.tx_ch = '0; i1.tx_word = '0; i1.in_data = '0; i1.in_strobe = 1'b0;
        i2.tx_valid = 1'b0; i2.tx_ch = '0; i2.tx_word = '0; i2.in_data = '0; i2.in_strobe = 1'b0;
        i3.tx_valid = 1'b0; i3.tx_ch = '0; i3.tx_word = '0;
        #1;
        test_reset();
        test_tx_basic();
        test_tx_pace();
        test_back_to_back();
        test_rx_basic();
        test_rx_bad_ch();
        test_rx_timeout();
        test_reset_mid();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
